// File: rtl/ps2_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : ps2_pkg
// Brief  : Shared PS/2 constants, frame layout and frame check helper.
// Rev    : 1.0
// ============================================================================
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    // Wire order on the pin: start first, stop last
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
        logic       start;
    } ps2_frame_t;

    function automatic logic ps2_frame_ok(input ps2_frame_t f);
        return !f.start && f.stop && (^{f.data, f.parity});
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module : ps2_rx_fifo_if
// Brief  : PS/2 pins plus the scan-code pop interface of the receiver.
// Rev    : 1.0
// ============================================================================
interface ps2_rx_fifo_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        input  nextdata_n,
        output data,
        output ready,
        output overflow,
        output frame_err
    );

    modport master (
        output ps2_clk,
        output ps2_data,
        output nextdata_n,
        input  data,
        input  ready,
        input  overflow,
        input  frame_err
    );
endinterface
`default_nettype wire

// File: rtl/ps2_rx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO, combinational head, sticky overflow on drop.
// Rev    : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             r_overflow;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_drop;

    assign empty     = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot the write lands in
    assign w_push_ok = push && (!w_full || w_pop_ok);
    assign w_drop    = push && w_full && !w_pop_ok;
    assign dout      = empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (rstn && w_push_ok)
            r_mem[r_wptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)
                r_rptr <= r_rptr + 1'b1;
            if (w_drop)
                r_overflow <= 1'b1;
            else if (w_pop_ok)
                r_overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module : ps2_rx_fifo
// Brief  : PS/2 pin synchroniser, frame deserialiser/checker and byte FIFO.
// Rev    : 1.0
// ============================================================================
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  wire logic    clk,
    input  wire logic    rstn,
    ps2_rx_fifo_if.slave bus
);
    localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]        LAST_BIT  = 4'(PS2_FRAME_BITS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic              r_clk_s1;
    logic              r_clk_s2;
    logic              r_clk_hist;
    logic              r_data_s1;
    logic              r_data_s2;
    logic [9:0]        r_shift;
    logic [3:0]        r_bitcnt;
    logic [IDLE_W-1:0] r_idle;
    ps2_frame_t        r_frame;
    logic              r_frame_vld;
    logic              r_frame_err;
    logic              w_fall;
    logic              w_timeout;
    logic              w_frame_ok;
    logic              w_push;
    logic              w_empty;

    // Synchronisers idle high to match an undriven PS/2 bus
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_hist <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            r_clk_s1   <= bus.ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_hist <= r_clk_s2;
            r_data_s1  <= bus.ps2_data;
            r_data_s2  <= r_data_s1;
        end
    end

    assign w_fall    = r_clk_hist && !r_clk_s2;
    assign w_timeout = !w_fall && (r_bitcnt != 4'd0) && (r_idle == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_idle      <= '0;
            r_frame     <= '0;
            r_frame_vld <= 1'b0;
        end else begin
            r_frame_vld <= 1'b0;
            if (w_fall) begin
                r_idle <= '0;
                if (r_bitcnt == LAST_BIT) begin
                    r_frame     <= ps2_frame_t'({r_data_s2, r_shift});
                    r_frame_vld <= 1'b1;
                    r_bitcnt    <= '0;
                    r_shift     <= '0;
                end else begin
                    r_shift  <= {r_data_s2, r_shift[9:1]};
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (r_bitcnt == 4'd0) begin
                r_idle <= '0;
            end else if (w_timeout) begin
                r_idle   <= '0;
                r_bitcnt <= '0;
                r_shift  <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    // The completed frame is judged one cycle after capture
    assign w_frame_ok = ps2_frame_ok(r_frame);
    assign w_push     = r_frame_vld && w_frame_ok;

    always_ff @(posedge clk) begin
        if (!rstn)
            r_frame_err <= 1'b0;
        else
            r_frame_err <= (r_frame_vld && !w_frame_ok) || w_timeout;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (w_push),
        .din      (r_frame.data),
        .pop      (!bus.nextdata_n),
        .dout     (bus.data),
        .empty    (w_empty),
        .overflow (bus.overflow)
    );

    assign bus.ready     = !w_empty;
    assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_ps2_rx_fifo
// Brief  : Self-checking bench for ps2_rx_fifo with a byte scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 10;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;
    int   err_cnt;
    logic [7:0] exp_q[$];

    ps2_rx_fifo_if bus();

    ps2_rx_fifo #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1)
            err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par);
        logic p;
        p = ~(^d) ^ bad_par;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++)
            ps2_bit(fr[i]);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(make_frame(d, 1'b0), 11);
        repeat (4) @(negedge clk);
    endtask

    // Checks the head against the scoreboard and pops for one cycle
    task automatic pop_check(input string name);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, ready=%0b data=%02h", name, bus.ready, bus.data);
        end else begin
            e = exp_q.pop_front();
            if (bus.ready !== 1'b1 || bus.data !== e) begin
                failures++;
                $display("FAIL %s: ready=%0b data=%02h, want ready=1 data=%02h",
                         name, bus.ready, bus.data, e);
            end
        end
        bus.nextdata_n = 1'b0;
        @(negedge clk);
        bus.nextdata_n = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0 || bus.overflow !== 1'b0 || bus.frame_err !== 1'b0 || bus.data !== 8'h00) begin
            failures++;
            $display("FAIL reset: ready=%0b ovf=%0b ferr=%0b data=%02h, want 0 0 0 00",
                     bus.ready, bus.overflow, bus.frame_err, bus.data);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [10:0] fr;
        int e0;
        e0 = err_cnt;
        fr = make_frame(8'h1C, 1'b0);
        send_bits(fr, 10);
        bus.ps2_data = fr[10];
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        exp_q.push_back(8'h1C);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL single_latency_early: ready=%0b after 3 clk, want 0", bus.ready);
        end
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1 || bus.data !== 8'h1C) begin
            failures++;
            $display("FAIL single_latency: ready=%0b data=%02h after 4 clk, want 1 1c", bus.ready, bus.data);
        end
        repeat (HALF - 4) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (err_cnt != e0) begin
            failures++;
            $display("FAIL single_ferr: frame_err pulses=%0d, want 0", err_cnt - e0);
        end
        pop_check("single_pop");
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL single_empty: ready=%0b, want 0", bus.ready);
        end
    endtask

    task automatic test_parity();
        int e0;
        e0 = err_cnt;
        send_bits(make_frame(8'h45, 1'b1), 11);
        repeat (6) @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL parity_nopush: ready=%0b, want 0", bus.ready);
        end
        checks++;
        if (err_cnt != e0 + 1) begin
            failures++;
            $display("FAIL parity_ferr: frame_err pulses=%0d, want 1", err_cnt - e0);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            send_byte(8'(i));
            if (i <= DEPTH)
                exp_q.push_back(8'(i));
        end
        checks++;
        if (bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: overflow=%0b, want 1", bus.overflow);
        end
        pop_check("overflow_pop_first");
        checks++;
        if (bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear: overflow=%0b, want 0", bus.overflow);
        end
        for (int i = 1; i < DEPTH; i++)
            pop_check("overflow_drain");
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL overflow_empty: ready=%0b, want 0", bus.ready);
        end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        send_bits(make_frame(8'hAA, 1'b0), 5);
        repeat (TIMEOUT + 5) @(negedge clk);
        checks++;
        if (err_cnt != e0 + 1) begin
            failures++;
            $display("FAIL timeout_ferr: frame_err pulses=%0d, want 1", err_cnt - e0);
        end
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL timeout_nopush: ready=%0b, want 0", bus.ready);
        end
        send_byte(8'h16);
        exp_q.push_back(8'h16);
        pop_check("timeout_next_frame");
    endtask

    task automatic test_full_pop_same_cycle();
        logic [10:0] fr;
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(8'hA0 + 8'(i));
            exp_q.push_back(8'hA0 + 8'(i));
        end
        fr = make_frame(8'hA8, 1'b0);
        send_bits(fr, 10);
        bus.ps2_data = fr[10];
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(8'hA8);
        pop_check("coincide_pop");
        checks++;
        if (bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL coincide_overflow: overflow=%0b, want 0", bus.overflow);
        end
        repeat (HALF - 4) @(negedge clk);
        bus.ps2_clk = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++)
            pop_check("coincide_order");
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL coincide_empty: ready=%0b, want 0", bus.ready);
        end
    endtask

    task automatic test_reset_midframe();
        int e0;
        send_byte(8'h33);
        send_bits(make_frame(8'h5A, 1'b0), 6);
        rstn = 1'b0;
        @(negedge clk);
        exp_q.delete();
        checks++;
        if (bus.ready !== 1'b0 || bus.overflow !== 1'b0 || bus.frame_err !== 1'b0 || bus.data !== 8'h00) begin
            failures++;
            $display("FAIL midreset: ready=%0b ovf=%0b ferr=%0b data=%02h, want 0 0 0 00",
                     bus.ready, bus.overflow, bus.frame_err, bus.data);
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        e0 = err_cnt;
        send_byte(PS2_BREAK);
        exp_q.push_back(PS2_BREAK);
        pop_check("midreset_next_frame");
        checks++;
        if (err_cnt != e0) begin
            failures++;
            $display("FAIL midreset_ferr: frame_err pulses=%0d, want 0", err_cnt - e0);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        err_cnt        = 0;
        rstn           = 1'b0;
        bus.ps2_clk    = 1'b1;
        bus.ps2_data   = 1'b1;
        bus.nextdata_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_parity();
        test_overflow();
        test_timeout();
        test_full_pop_same_cycle();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 keyboard receiver front end: synchronises the raw `ps2_clk`/`ps2_data` pins and deserialises 11-bit frames. It checks start, stop and odd parity, then buffers valid scan-code bytes in a small FIFO. It sits directly upstream of the key/segment display top, which pops one byte per `ready` by pulsing `nextdata_n` low. `overflow` and `frame_err` report lost bytes.

## Interface
- `FIFO_DEPTH`, 8: entries; power of two, ≥2.
- `TIMEOUT_CYC`, 10000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned (200 µs at 50 MHz).
- `clk` in 1: system clock, all logic on posedge.
- `rstn` in 1: reset, synchronous, active-low.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `nextdata_n` in 1: active-low pop request; honoured only while `ready`=1.
- `data` out 8: FIFO head byte; valid while `ready`=1.
- `ready` out 1: FIFO non-empty.
- `overflow` out 1: sticky; a valid frame was dropped because the FIFO was full.
- `frame_err` out 1: one-cycle pulse on a start/stop/parity error or a timeout abort.

## Operation
- Both pins pass through a 2-FF synchroniser. A third register on the clock path forms `ps2_clk` history. A falling edge is detected when history is `1→0`.
- On each falling edge the synchronised data bit is shifted into a 10-bit shift register, LSB first, and the 4-bit bit counter increments.
- On the 11th edge: start=bit0 must be 0, stop=bit10 must be 1, and XOR of data[7:0]^parity must be 1 (odd). The counter returns to 0.
  - Valid frame: push data[7:0].
  - Invalid frame: no push; `frame_err` pulses.
- Timeout: if bitcnt≠0 and `TIMEOUT_CYC` cycles pass with no falling edge, set bitcnt to 0, discard the partial frame and pulse `frame_err`. The idle counter resets on every falling edge and holds at 0 when bitcnt=0.
- Pop: when `ready`=1 and `nextdata_n`=0 at a clk edge, advance the read pointer. Pop while empty is ignored.
- Push when full:
  - Accepted only if a pop happens in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set.
- `overflow` clears on reset or on any successful pop. If set and clear coincide, set wins.
- Pointers are log2(DEPTH)+1 bits wide; full/empty is decided by MSB compare. `count` wraps naturally.
- Reset values: `ready`=0, `overflow`=0, `frame_err`=0, `data`=8'h00. Pointers, bitcnt, shift register and idle counter are 0. Synchroniser flops reset to 1 (idle bus).
- Reset mid-frame discards the partial frame and FIFO contents. The next falling edge is treated as a start bit.

## Timing
- Pin fall → edge detected: 3 clk. The bit is captured on that edge.
- 11th ps2_clk fall → `ready` high: 4 clk. Empty-FIFO `data` is valid in the same cycle as `ready`.
- Pop at edge N → `data` shows the next entry and `ready` updates at N+1. There is no read latency; the head is driven combinationally from the memory array.
- `frame_err` is high exactly 1 clk, in the cycle after the checking edge.
- Back-to-back pops every cycle are legal. Throughput is 1 byte/clk out and is bounded by the PS/2 rate in.

## Structure
- Shared package `ps2_pkg`:
  - `PS2_FRAME_BITS`=11.
  - Scan-code constants `PS2_EXT`=8'hE0 and `PS2_BREAK`=8'hF0, used by downstream decoders.
- Sub-module `sync_fifo` (params WIDTH, DEPTH) holds storage, pointers, full/empty and the push-while-full-with-pop rule.
- Synchroniser, deserialiser, checker and timeout stay in `ps2_rx_fifo`.

## Test plan
- Send frame for 8'h1C with odd parity bit 0 → `data`=8'h1C, `ready`=1, 4 clk after the 11th fall; `frame_err`=0.
- Send 8'h45 with a wrong parity bit → no push, `ready` stays 0, `frame_err` pulses once.
- Send 9 valid bytes 8'h01..8'h09 with no pops (DEPTH=8) → `overflow`=1; pops return 01..08, `overflow` clears on the first pop.
- Send 5 bits, then hold `ps2_clk` high for `TIMEOUT_CYC`+5 cycles → `frame_err` pulse; the following full frame 8'h16 is received correctly.
- FIFO full with a 9th frame completing in the same cycle as a pop → byte accepted, `overflow` stays 0, order preserved.
- Assert `rstn`=0 for 1 clk after 6 bits of a frame → outputs at reset values; the next frame 8'hF0 is received correctly.
